// File: rtl/if_fetch_stage_pkg.sv
// if_fetch_stage_pkg: shared widths, state encoding and bus layouts for the
// instruction-fetch stage.
// Optional feature macro: IF_ADEF_CHECK_EN. It widens the fetch-to-decode bus
// by one bit, the fetch address-error flag.
package if_fetch_stage_pkg;

  localparam int BR_BUS_WD = 33;
`ifdef IF_ADEF_CHECK_EN
  localparam int FS_TO_DS_BUS_WD = 65;
`else
  localparam int FS_TO_DS_BUS_WD = 64;
`endif

  localparam logic [31:0] RESET_PC_DEF = 32'hbfc00000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } fs_state_t;

  // {br_taken, br_target} as driven by decode
  typedef struct packed {
    logic        br_taken;
    logic [31:0] br_target;
  } br_bus_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: SRAM-like instruction port (req/addr_ok/data_ok).
//   master: fetch stage (drives req/wr/size/addr/wdata)
//   slave : instruction memory (drives addr_ok/data_ok/rdata)
interface if_fetch_stage_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (output req, wr, size, addr, wdata,
                  input  addr_ok, data_ok, rdata);
  modport slave  (input  req, wr, size, addr, wdata,
                  output addr_ok, data_ok, rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: MIPS IF stage. Fetches one word at a time from the
// instruction SRAM port, buffers it if ID stalls, and hands it to ID under a
// valid/allowin handshake. Next PC is fs_pc+4 or, when ID's branch leaves ID
// at hand-off, the branch target (the word handed off is the delay slot).
// Ports:
//   clk, reset       clock; synchronous active-high reset
//   ds_allowin       ID can accept this cycle
//   br_bus           {br_taken, br_target} from ID, sampled only at hand-off
//   fs_to_ds_valid   instruction valid toward ID
//   fs_to_ds_bus     {[fs_adef,] inst, pc}
//   inst_sram        SRAM-like instruction port (master side)
// Optional feature macro: IF_ADEF_CHECK_EN -- misaligned fs_pc issues no
// request and delivers inst=0 with fs_adef set.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  if_fetch_stage_if.master           inst_sram
);

  fs_state_t   state, state_nxt;
  logic [31:0] fs_pc;
  logic [31:0] inst_buf;
  logic [31:0] buf_d;
  logic [31:0] inst_out;
  logic        buf_we;
  logic        req_c;
  logic        valid_c;
  logic        handoff;
  logic        misaligned;
  br_bus_t     br;

  assign br = br_bus_t'(br_bus);

`ifdef IF_ADEF_CHECK_EN
  logic fs_adef;
  assign misaligned = |fs_pc[1:0];
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    req_c     = 1'b0;
    valid_c   = 1'b0;
    inst_out  = inst_buf;
    buf_we    = 1'b0;
    buf_d     = inst_sram.rdata;
    unique case (state)
      S_REQ: begin
        if (misaligned) begin
          // address error: skip memory, present a zero word flagged fs_adef
          state_nxt = S_FULL;
          buf_we    = 1'b1;
          buf_d     = '0;
        end else begin
          req_c = 1'b1;
          if (inst_sram.addr_ok) state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (inst_sram.data_ok) begin
          if (ds_allowin) begin
            // bypass: return data goes straight to ID
            valid_c   = 1'b1;
            inst_out  = inst_sram.rdata;
            state_nxt = S_REQ;
          end else begin
            buf_we    = 1'b1;
            state_nxt = S_FULL;
          end
        end
      end
      S_FULL: begin
        valid_c = 1'b1;
        if (ds_allowin) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  // gate with reset so nothing leaks out while the flops are being cleared
  assign inst_sram.req   = req_c & ~reset;
  assign fs_to_ds_valid  = valid_c & ~reset;
  assign handoff         = fs_to_ds_valid & ds_allowin;

  assign inst_sram.wr    = 1'b0;
  assign inst_sram.size  = 2'd2;
  assign inst_sram.addr  = fs_pc;
  assign inst_sram.wdata = 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_REQ;
      fs_pc    <= RESET_PC;
      inst_buf <= 32'd0;
    end else begin
      state <= state_nxt;
      if (buf_we) inst_buf <= buf_d;
      // ID's branch leaves ID with this hand-off, so br_bus is final here
      if (handoff) fs_pc <= br.br_taken ? br.br_target : fs_pc + 32'd4;
    end
  end

`ifdef IF_ADEF_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset)                           fs_adef <= 1'b0;
    else if (handoff)                    fs_adef <= 1'b0;
    else if (state == S_REQ && misaligned) fs_adef <= 1'b1;
  end
  assign fs_to_ds_bus = {fs_adef, inst_out, fs_pc};
`else
  assign fs_to_ds_bus = {inst_out, fs_pc};
`endif

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Producer of `fs_to_ds_bus` and consumer of `br_bus`; decode (ID) sits on the other end of both.
- Fetches one instruction at a time over the SRAM-like instruction port (req/addr_ok/data_ok), buffers it, and hands it to ID under a valid/allowin handshake.
- Selects the next PC: sequential, or the branch target after the delay slot.

Parameters:
- RESET_PC, 32'hbfc00000, PC of the first fetch after reset.

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- ds_allowin  in  1  ID can accept an instruction this cycle
- br_bus  in  `BR_BUS_WD` (33)  {br_taken, br_target[31:0]} from ID; combinational, meaningful only while ID holds a valid instruction
- fs_to_ds_valid  out  1  fetched instruction valid toward ID
- fs_to_ds_bus  out  `FS_TO_DS_BUS_WD` (64)  {inst[31:0], pc[31:0]}; pc field = fs_pc in every state
- inst_sram_req  out  1  fetch request
- inst_sram_wr  out  1  constant 0
- inst_sram_size  out  2  constant 2'd2 (word)
- inst_sram_addr  out  32  = fs_pc
- inst_sram_wdata  out  32  constant 0
- inst_sram_addr_ok  in  1  request accepted
- inst_sram_data_ok  in  1  read data returned
- inst_sram_rdata  in  32  instruction word

Behaviour:
- Registers:
  - fs_pc: PC of the instruction in flight.
  - state.
  - inst_buf[31:0].
- States: S_REQ, S_WAIT, S_FULL. Only one request is outstanding at a time.
- Reset:
  - state = S_REQ, fs_pc = RESET_PC, inst_buf = 0.
  - During reset: inst_sram_req = 0 and fs_to_ds_valid = 0.
  - The SRAM port shares the same reset, so no stale data_ok arrives after reset; reset mid-request simply restarts at RESET_PC.
- S_REQ:
  - inst_sram_req = 1, addr = fs_pc.
  - addr_ok=1 → S_WAIT; otherwise stay. The request stays stable until accepted.
- S_WAIT:
  - req = 0.
  - data_ok=1 & ds_allowin=1 → bypass: fs_to_ds_valid = 1 this cycle with inst = inst_sram_rdata; hand-off occurs; go to S_REQ.
  - data_ok=1 & ds_allowin=0 → inst_buf ← rdata, go to S_FULL.
  - Otherwise stay.
- S_FULL:
  - fs_to_ds_valid = 1, inst = inst_buf.
  - ds_allowin=1 → hand-off, go to S_REQ; otherwise hold, with all outputs stable.
- Hand-off = fs_to_ds_valid & ds_allowin. On hand-off: fs_pc ← br_taken ? br_target : fs_pc + 4 (32-bit wrap, no carry out).
- Branch/delay-slot rule:
  - br_taken is sampled only at hand-off.
  - At that cycle ID's branch is leaving ID, so br_bus is final. The instruction being handed off is the delay slot, and the next fetch is the target.
  - br_bus is ignored in every other cycle, including ID stalls.
- fs_to_ds_bus.pc = fs_pc always; ID uses it combinationally as delay-slot PC for target computation.
- Outside the two valid cases, fs_to_ds_valid = 0 and the inst field = inst_buf.
- Minimum throughput: 2 cycles/instruction (bypass path).

Optional Feature:
- Macro IF_ADEF_CHECK_EN.
- Defined:
  - `FS_TO_DS_BUS_WD` = 65, bit 64 = fs_adef.
  - In S_REQ with fs_pc[1:0] != 0: no request issued; next state S_FULL with inst_buf = 0 and fs_adef = 1.
  - fs_adef clears on hand-off.
- Undefined:
  - Width 64; no alignment check; the misaligned address is issued as-is.

Decomposition:
- mycpu.h holds:
  - `BR_BUS_WD` and `FS_TO_DS_BUS_WD`.
  - State encodings as `define constants (S_REQ=2'd0, S_WAIT=2'd1, S_FULL=2'd2).
  - RESET_PC default.
- No sub-module; single module, roughly 150 lines.

Test Plan:
- Reset held 3 cycles, SRAM answers addr_ok immediately, data_ok next cycle with 32'h24010001, ds_allowin=1.
  - Required: req first high the cycle after reset drops, addr 32'hbfc00000.
  - Required: fs_to_ds_valid pulses with bus {32'h24010001, 32'hbfc00000}.
  - Required: next addr 32'hbfc00004.
- addr_ok delayed 4 cycles.
  - Required: req and addr held stable for all 4 cycles.
  - Required: exactly one request is accepted.
- data_ok arrives while ds_allowin=0 for 5 cycles.
  - Required: S_FULL; valid high with inst stable; no new req until hand-off.
- Hand-off of delay slot at pc 32'hbfc00010 with br_bus = {1, 32'hbfc00100}.
  - Required: next req addr 32'hbfc00100.
- Same hand-off with br_taken=0.
  - Required: next req addr 32'hbfc00014.
- br_taken=1 while ds_allowin=0.
  - Required: ignored; fs_pc unchanged until hand-off.
- With IF_ADEF_CHECK_EN defined, br_target = 32'hbfc00102.
  - Required: no req issued; bus = {1, 32'h0, 32'hbfc00102}.
